// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the datapath and the PC sequencer.
// The datapath side is master, the sequencer is slave.
interface pc_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             run_en;
  logic             step_i;
  logic             halt_i;
  logic             stall_i;
  logic             redirect_i;
  logic [31:0]      redirect_pc_i;
  logic [31:0]      pc_o;
  logic             fetch_en_o;
  logic             flush_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] fetch_cnt_o;

  modport master (
    output run_en, step_i, halt_i, stall_i,
    output redirect_i, redirect_pc_i,
    input  pc_o, fetch_en_o, flush_o,
    input  state_o, fetch_cnt_o
  );

  modport slave (
    input  run_en, step_i, halt_i, stall_i,
    input  redirect_i, redirect_pc_i,
    output pc_o, fetch_en_o, flush_o,
    output state_o, fetch_cnt_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC owner and run controller: free-run, single-step, halt.
// Priority in fetching states: halt > redirect > stall > increment.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input logic          clk,
  input logic          rstn,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    PAUSE  = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } st_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  st_t              st_q, st_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_q, flush_d;
  logic             fen_q, fen_d;
  logic             step_q;

  logic fetching;
  logic step_edge;
  logic do_halt;
  logic do_redir;
  logic do_inc;
  logic adv;

  always_comb begin
    fetching  = (st_q == RUN) || (st_q == STEP);
    step_edge = bus.step_i & ~step_q;
    do_halt   = fetching & bus.halt_i;
    do_redir  = (st_q != HALTED) & ~do_halt & bus.redirect_i;
    do_inc    = fetching & ~do_halt & ~bus.redirect_i & ~bus.stall_i;
    // A redirect counts as an advance even when stalled
    adv       = fetching & ~do_halt & (bus.redirect_i | ~bus.stall_i);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q  <= PAUSE;
      fen_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      fen_q <= fen_d;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      PAUSE: begin
        if (bus.run_en)
          st_d = RUN;
        else if (step_edge)
          st_d = STEP;
      end
      RUN: begin
        if (do_halt)
          st_d = HALTED;
        else if (!bus.run_en)
          st_d = PAUSE;
      end
      STEP: begin
        if (do_halt)
          st_d = HALTED;
        else if (adv)
          st_d = PAUSE;
      end
      HALTED: st_d = HALTED;
      default: st_d = PAUSE;
    endcase
    fen_d = (st_d == RUN) || (st_d == STEP);
  end

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    flush_d = 1'b0;
    unique case (1'b1)
      do_redir: begin
        pc_d    = bus.redirect_pc_i & ~32'h3;
        flush_d = 1'b1;
      end
      do_inc:  pc_d = pc_q + 32'd4;
      default: pc_d = pc_q;
    endcase
    if (adv)
      cnt_d = cnt_q + CNT_ONE;
  end

  // step_q resets high so a level held through reset is not an edge
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      flush_q <= 1'b0;
      step_q  <= 1'b1;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
      step_q  <= bus.step_i;
    end
  end

  assign bus.pc_o        = pc_q;
  assign bus.fetch_en_o  = fen_q;
  assign bus.flush_o     = flush_q;
  assign bus.state_o     = st_q;
  assign bus.fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed table, corner sequences,
// then random stimulus against a behavioural model.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int P = 0, R = 1, S = 2, H = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  pc_sequencer_if #(.CNT_W(32)) bus ();

  pc_sequencer #(.RESET_PC(RST_PC), .CNT_W(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    bit          run, step, halt, stall, redir;
    logic [31:0] rpc;
    logic [31:0] pc;
    int          st;
    bit          fl;
    int unsigned cnt;
  } vec_t;

  vec_t vecs[$];

  // behavioural model
  logic [31:0] m_pc;
  int unsigned m_cnt;
  int          m_mode;
  bit          m_flush;
  bit          m_stepq;

  function automatic vec_t mk(bit r, bit s, bit h, bit st, bit rd,
                              logic [31:0] rpc, logic [31:0] pc,
                              int md, bit fl, int unsigned cnt);
    vec_t v;
    v.run = r; v.step = s; v.halt = h; v.stall = st; v.redir = rd;
    v.rpc = rpc; v.pc = pc; v.st = md; v.fl = fl; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_cnt = 0; m_mode = P; m_flush = 0; m_stepq = 1;
  endtask

  task automatic model_edge();
    bit fetch;
    bit moved;
    fetch = (m_mode == R) || (m_mode == S);
    moved = 0;
    m_flush = 0;
    if (m_mode == H) begin
    end else if (fetch && bus.halt_i) begin
      m_mode = H;
    end else begin
      if (bus.redirect_i) begin
        m_pc = {bus.redirect_pc_i[31:2], 2'b00};
        m_flush = 1;
        moved = fetch;
      end else if (fetch && !bus.stall_i) begin
        m_pc = m_pc + 4;
        moved = 1;
      end
      if (moved) m_cnt++;
      if (m_mode == P) begin
        if (bus.run_en) m_mode = R;
        else if (bus.step_i && !m_stepq) m_mode = S;
      end else if (m_mode == R) begin
        if (!bus.run_en) m_mode = P;
      end else if (moved) begin
        m_mode = P;
      end
    end
    m_stepq = bus.step_i;
  endtask

  task automatic check_model();
    chk("pc", bus.pc_o, m_pc);
    chk("state", 32'(bus.state_o), 32'(m_mode));
    chk("flush", 32'(bus.flush_o), 32'(m_flush));
    chk("cnt", bus.fetch_cnt_o, m_cnt);
    chk("fetch_en", 32'(bus.fetch_en_o), 32'((m_mode == R) || (m_mode == S)));
  endtask

  task automatic drive(bit r, bit s, bit h, bit st, bit rd, logic [31:0] rpc);
    bus.run_en = r; bus.step_i = s; bus.halt_i = h;
    bus.stall_i = st; bus.redirect_i = rd; bus.redirect_pc_i = rpc;
  endtask

  task automatic tick(input bit use_model);
    @(posedge clk);
    model_edge();
    #1;
    if (use_model) check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    model_reset();
    #1;
    check_model();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    vecs.push_back(mk(1,0,0,0,0,0,          32'h0,        R,0,0));
    vecs.push_back(mk(1,0,0,0,0,0,          32'h4,        R,0,1));
    vecs.push_back(mk(1,0,0,0,0,0,          32'h8,        R,0,2));
    vecs.push_back(mk(1,0,0,0,0,0,          32'hC,        R,0,3));
    vecs.push_back(mk(1,0,0,0,0,0,          32'h10,       R,0,4));
    vecs.push_back(mk(1,0,0,1,0,0,          32'h10,       R,0,4));
    vecs.push_back(mk(1,0,0,1,0,0,          32'h10,       R,0,4));
    vecs.push_back(mk(1,0,0,0,1,32'h43,     32'h40,       R,1,5));
    vecs.push_back(mk(1,0,0,0,0,0,          32'h44,       R,0,6));
    vecs.push_back(mk(1,0,0,0,1,32'hFFFF_FFFF,32'hFFFF_FFFC,R,1,7));
    vecs.push_back(mk(1,0,0,0,0,0,          32'h0,        R,0,8));
    vecs.push_back(mk(1,0,0,0,1,32'h100,    32'h100,      R,1,9));
    vecs.push_back(mk(1,0,0,1,1,32'h205,    32'h204,      R,1,10));
    vecs.push_back(mk(0,0,0,0,0,0,          32'h208,      P,0,11));
    vecs.push_back(mk(0,1,0,0,0,0,          32'h208,      S,0,11));
    vecs.push_back(mk(0,1,0,0,0,0,          32'h20C,      P,0,12));
    vecs.push_back(mk(0,1,0,0,0,0,          32'h20C,      P,0,12));
    vecs.push_back(mk(0,0,0,0,0,0,          32'h20C,      P,0,12));
    vecs.push_back(mk(0,1,0,1,0,0,          32'h20C,      S,0,12));
    vecs.push_back(mk(0,1,0,1,0,0,          32'h20C,      S,0,12));
    vecs.push_back(mk(0,0,0,1,0,0,          32'h20C,      S,0,12));
    vecs.push_back(mk(0,0,0,0,0,0,          32'h210,      P,0,13));
    vecs.push_back(mk(0,0,0,0,1,32'h3001,   32'h3000,     P,1,13));
    vecs.push_back(mk(1,0,0,0,0,0,          32'h3000,     R,0,13));
    vecs.push_back(mk(1,0,1,0,1,32'h80,     32'h3000,     H,0,13));
    vecs.push_back(mk(0,1,0,1,1,32'h44,     32'h3000,     H,0,13));
    vecs.push_back(mk(1,0,0,0,0,0,          32'h3000,     H,0,13));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].run, vecs[i].step, vecs[i].halt,
            vecs[i].stall, vecs[i].redir, vecs[i].rpc);
      tick(0);
      chk($sformatf("v%0d_pc", i), bus.pc_o, vecs[i].pc);
      chk($sformatf("v%0d_st", i), 32'(bus.state_o), 32'(vecs[i].st));
      chk($sformatf("v%0d_fl", i), 32'(bus.flush_o), 32'(vecs[i].fl));
      chk($sformatf("v%0d_cnt", i), bus.fetch_cnt_o, vecs[i].cnt);
      chk($sformatf("v%0d_fen", i), 32'(bus.fetch_en_o),
          32'((vecs[i].st == R) || (vecs[i].st == S)));
    end

    // step_i held high through reset must not produce a step
    drive(0, 1, 0, 0, 0, 0);
    do_reset();
    tick(1);
    tick(1);
    chk("held_step_state", 32'(bus.state_o), 32'(P));
    chk("held_step_pc", bus.pc_o, RST_PC);

    // async reset while flush is high clears it without waiting for a clock
    drive(0, 0, 0, 0, 1, 32'h55);
    tick(1);
    chk("pre_rst_flush", 32'(bus.flush_o), 32'd1);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("async_flush", 32'(bus.flush_o), 32'd0);
    chk("async_pc", bus.pc_o, RST_PC);
    chk("async_state", 32'(bus.state_o), 32'(P));
    @(negedge clk);
    rstn = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] t;
      t = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | 32'($urandom % 16))
                              : $urandom;
      drive(($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 40) == 0,
            ($urandom % 4) == 0, ($urandom % 6) == 0, t);
      tick(1);
      if ((m_mode == H && ($urandom % 8) == 0) || ($urandom % 300) == 0)
        do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
